// File: rtl/clk_div_monitor.sv
// ---------------------------------------------------------------------------
// clk_div_monitor
//   Frequency checker for a locally divided clock. The divided clock is
//   sampled as ordinary data in the clk_i domain. Its rising edges are
//   counted over a programmable window of clk_i cycles, and the count is
//   compared against win_len / EXP_DIV within +/- TOL.
//
// Ports
//   clk_i       source clock, all logic on its rising edge
//   rst         asynchronous active-low reset
//   div_clk_i   divided clock under test (asynchronous data)
//   start_i     start a measurement (ignored unless idle)
//   win_len_i   window length in clk_i cycles, sampled with start_i
//   busy_o      high while measuring
//   done_o      one-cycle pulse when the results below are updated
//   edge_cnt_o  rising edges counted in the last window (saturating)
//   pass_o      last result within tolerance and not saturated
//   ovf_o       edge counter saturated in the last window
// ---------------------------------------------------------------------------
module clk_div_monitor #(
  parameter int WIN_W       = 16,
  parameter int CNT_W       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int EXP_DIV     = 4,
  parameter int TOL         = 1
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             div_clk_i,
  input  logic             start_i,
  input  logic [WIN_W-1:0] win_len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] edge_cnt_o,
  output logic             pass_o,
  output logic             ovf_o
);

  // EXP_DIV is a power of two, so the expected count is a plain shift.
  localparam int SHIFT = $clog2(EXP_DIV);
  // Signed difference wide enough for either operand plus a sign bit.
  localparam int DW    = ((WIN_W > CNT_W) ? WIN_W : CNT_W) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] res_cnt_q;
  logic             res_pass_q;
  logic             res_ovf_q;

  logic             start_ok;
  logic             last_cycle;
  logic [WIN_W-1:0] expected;
  logic signed [DW-1:0] diff;
  logic [DW-1:0]    abs_diff;
  logic             pass_d;

  // -------------------------------------------------------------------------
  // Synchroniser and edge detector. They run in every state so that the
  // prev register already tracks the line when a window opens; a level
  // that was high before start therefore produces no edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_clk_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  assign start_ok   = start_i && (win_len_i != '0);
  assign last_cycle = (win_cnt_q == (win_len_q - WIN_W'(1)));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)   state_d = MEASURE;
      MEASURE: if (last_cycle) state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      MEASURE: busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Saturating edge counter. An edge arriving at saturation leaves the count
  // alone and raises the overflow flag instead.
  // -------------------------------------------------------------------------
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    if (rise) begin
      if (&edge_cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
    end
  end

  // Verdict is computed from the next-state count so that an edge in the
  // final window cycle is included in the published result.
  always_comb begin
    expected = win_len_q >> SHIFT;
    diff     = $signed(DW'(edge_cnt_d)) - $signed(DW'(expected));
    abs_diff = (diff < 0) ? DW'(-diff) : DW'(diff);
    pass_d   = !ovf_d && (abs_diff <= DW'(TOL));
  end

  // -------------------------------------------------------------------------
  // Measurement datapath and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      win_len_q  <= '0;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      res_cnt_q  <= '0;
      res_pass_q <= 1'b0;
      res_ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            win_len_q  <= win_len_i;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
          end
        end
        MEASURE: begin
          win_cnt_q  <= win_cnt_q + WIN_W'(1);
          edge_cnt_q <= edge_cnt_d;
          ovf_q      <= ovf_d;
          // Results become visible together with done_o in the DONE cycle.
          if (last_cycle) begin
            res_cnt_q  <= edge_cnt_d;
            res_ovf_q  <= ovf_d;
            res_pass_q <= pass_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign edge_cnt_o = res_cnt_q;
  assign pass_o     = res_pass_q;
  assign ovf_o      = res_ovf_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_div_monitor
//   Self-checking bench for clk_div_monitor. A default-parameter instance
//   covers most scenarios; a CNT_W=4 instance covers saturation. The divided
//   clock is generated on the falling clk edge, and its sampled value at every
//   rising edge is recorded. The reference count is the number of 0->1
//   transitions in that record whose detection, SYNC_STAGES+1 cycles after the
//   line changed, falls inside the window.
// ---------------------------------------------------------------------------
module tb_clk_div_monitor;

  localparam int S       = 2;
  localparam int EXP_DIV = 4;
  localparam int TOL     = 1;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        div_clk = 1'b0;
  logic        start   = 1'b0;
  logic [15:0] win_len = '0;

  logic        busy1, done1, pass1, ovf1;
  logic [11:0] cnt1;
  logic        busy2, done2, pass2, ovf2;
  logic [3:0]  cnt2;

  int pass_count  = 0;
  int check_count = 0;

  bit sel = 1'b0;  // 0: default instance, 1: CNT_W=4 instance

  wire        obs_busy = sel ? busy2 : busy1;
  wire        obs_done = sel ? done2 : done1;
  wire        obs_pass = sel ? pass2 : pass1;
  wire        obs_ovf  = sel ? ovf2  : ovf1;
  wire [11:0] obs_cnt  = sel ? {8'd0, cnt2} : cnt1;

  always #5 clk = ~clk;

  clk_div_monitor #(.WIN_W(16), .CNT_W(12), .SYNC_STAGES(S),
                    .EXP_DIV(EXP_DIV), .TOL(TOL)) dut (
    .clk_i(clk), .rst(rst), .div_clk_i(div_clk), .start_i(start),
    .win_len_i(win_len), .busy_o(busy1), .done_o(done1),
    .edge_cnt_o(cnt1), .pass_o(pass1), .ovf_o(ovf1));

  clk_div_monitor #(.WIN_W(16), .CNT_W(4), .SYNC_STAGES(S),
                    .EXP_DIV(EXP_DIV), .TOL(TOL)) dut_small (
    .clk_i(clk), .rst(rst), .div_clk_i(div_clk), .start_i(start),
    .win_len_i(win_len), .busy_o(busy2), .done_o(done2),
    .edge_cnt_o(cnt2), .pass_o(pass2), .ovf_o(ovf2));

  // Record of div_clk as seen at each rising edge; cyc is the index of the
  // next rising edge.
  bit hist [65536];
  int cyc = 0;
  always @(posedge clk) begin
    if (cyc < 65536) hist[cyc] = div_clk;
    cyc = cyc + 1;
  end

  // Divided-clock generator: period div_per cycles, or a static level.
  int div_per   = 4;
  bit div_level = 1'b0;
  int div_ph    = 0;
  always @(negedge clk) begin
    if (div_per == 0) begin
      div_clk = div_level;
    end else begin
      div_ph  = (div_ph + 1) % div_per;
      div_clk = (div_ph < div_per / 2);
    end
  end

  task automatic set_div(input int per, input bit lvl, input int ph);
    @(posedge clk);
    #1;
    div_per   = per;
    div_level = lvl;
    div_ph    = ph;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Rising edges of div_clk counted by a window that opens after start edge k.
  function automatic int model_edges(input int k, input int wl);
    int n = 0;
    for (int t = k + 1 - S; t <= k + wl - S; t++) begin
      if (t >= 1 && hist[t] && !hist[t-1]) n++;
    end
    return n;
  endfunction

  // One measurement: start, wait for done, compare timing and results with
  // the model, then confirm the bench stays quiet and results hold.
  task automatic run_measure(input int wl, input int cmax, input bit poke,
                             output int cnt_m, output bit pass_m);
    int  k, raw, exp_cnt, diff, busy_n, done_cyc, extra;
    bit  got, ovf_m;
    logic [11:0] held;
    @(negedge clk);
    k       = cyc;
    start   = 1'b1;
    win_len = 16'(wl);
    @(negedge clk);
    start  = 1'b0;
    got    = 1'b0;
    busy_n = 0;
    done_cyc = -1;
    for (int n = 0; n < wl + 10 && !got; n++) begin
      if (n > 0) @(negedge clk);
      start = poke && (n == 10);
      if (poke && n == 10) win_len = 16'd7;
      if (obs_busy) busy_n++;
      if (obs_done) begin
        got      = 1'b1;
        done_cyc = cyc;
        start    = poke;  // start in the DONE cycle must be ignored
      end
    end

    raw     = model_edges(k, wl);
    cnt_m   = (raw > cmax) ? cmax : raw;
    ovf_m   = (raw > cmax);
    exp_cnt = wl / EXP_DIV;
    diff    = cnt_m - exp_cnt;
    if (diff < 0) diff = -diff;
    pass_m  = !ovf_m && (diff <= TOL);

    $display("run wl=%0d k=%0d done_cyc=%0d cnt=%0d model=%0d pass=%0b ovf=%0b",
             wl, k, done_cyc, obs_cnt, cnt_m, obs_pass, obs_ovf);

    check_count++;
    if (done_cyc !== k + wl + 1)
      $display("FAIL done_timing: got cycle %0d expected %0d", done_cyc, k + wl + 1);
    else pass_count++;

    check_count++;
    if (busy_n !== wl)
      $display("FAIL busy_len: got %0d expected %0d", busy_n, wl);
    else pass_count++;

    check_count++;
    if (obs_cnt !== 12'(cnt_m))
      $display("FAIL edge_cnt: got %0d expected %0d", obs_cnt, cnt_m);
    else pass_count++;

    check_count++;
    if (obs_ovf !== ovf_m)
      $display("FAIL ovf: got %0b expected %0b", obs_ovf, ovf_m);
    else pass_count++;

    check_count++;
    if (obs_pass !== pass_m)
      $display("FAIL pass: got %0b expected %0b", obs_pass, pass_m);
    else pass_count++;

    held  = obs_cnt;
    extra = 0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (obs_done || obs_busy || obs_cnt !== held) extra++;
      @(negedge clk);
    end
    check_count++;
    if (extra !== 0)
      $display("FAIL quiet_after_done: got %0d active cycles expected 0", extra);
    else pass_count++;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    check_count++;
    if ({busy1, done1, cnt1, pass1, ovf1} !== '0)
      $display("FAIL reset_outputs: got %0h expected 0", {busy1, done1, cnt1, pass1, ovf1});
    else pass_count++;
    check_count++;
    if ({busy2, done2, cnt2, pass2, ovf2} !== '0)
      $display("FAIL reset_outputs_small: got %0h expected 0", {busy2, done2, cnt2, pass2, ovf2});
    else pass_count++;
    idle_cycles(3);
    rst = 1'b1;
    idle_cycles(8);
  endtask

  task automatic test_nominal;
    int c; bit p;
    set_div(4, 1'b0, $urandom_range(0, 3));
    idle_cycles(4);
    run_measure(64, 4095, 1'b0, c, p);
    check_count++;
    if (obs_cnt < 15 || obs_cnt > 17 || obs_pass !== 1'b1)
      $display("FAIL nominal_range: got cnt %0d pass %0b expected 15..17 pass 1", obs_cnt, obs_pass);
    else pass_count++;
  endtask

  task automatic test_wrong_ratio;
    int c; bit p;
    set_div(8, 1'b0, $urandom_range(0, 7));
    idle_cycles(4);
    run_measure(64, 4095, 1'b0, c, p);
    check_count++;
    if (obs_cnt < 7 || obs_cnt > 9 || obs_pass !== 1'b0)
      $display("FAIL wrong_ratio_range: got cnt %0d pass %0b expected 7..9 pass 0", obs_cnt, obs_pass);
    else pass_count++;
  endtask

  task automatic test_stopped;
    int c; bit p;
    for (int lvl = 0; lvl < 2; lvl++) begin
      set_div(0, lvl[0], 0);
      idle_cycles(6);
      run_measure(100, 4095, 1'b0, c, p);
      check_count++;
      if (obs_cnt !== 12'd0 || obs_pass !== 1'b0)
        $display("FAIL stopped_level%0d: got cnt %0d pass %0b expected 0 pass 0", lvl, obs_cnt, obs_pass);
      else pass_count++;
    end
  endtask

  task automatic test_overflow;
    int c; bit p;
    sel = 1'b1;
    set_div(2, 1'b0, 0);
    idle_cycles(4);
    run_measure(64, 15, 1'b0, c, p);
    check_count++;
    if (obs_cnt !== 12'd15 || obs_ovf !== 1'b1 || obs_pass !== 1'b0)
      $display("FAIL overflow: got cnt %0d ovf %0b pass %0b expected 15 1 0", obs_cnt, obs_ovf, obs_pass);
    else pass_count++;
    set_div(4, 1'b0, $urandom_range(0, 3));
    idle_cycles(4);
    run_measure(32, 15, 1'b0, c, p);
    check_count++;
    if (obs_ovf !== 1'b0 || obs_pass !== 1'b1 || obs_cnt < 7 || obs_cnt > 9)
      $display("FAIL overflow_recover: got cnt %0d ovf %0b pass %0b expected 7..9 0 1", obs_cnt, obs_ovf, obs_pass);
    else pass_count++;
    sel = 1'b0;
  endtask

  task automatic test_control;
    int c, act; bit p;
    set_div(4, 1'b0, 0);
    @(negedge clk);
    start   = 1'b1;
    win_len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    act   = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy1 || done1) act++;
      @(negedge clk);
    end
    check_count++;
    if (act !== 0)
      $display("FAIL zero_window: got %0d active cycles expected 0", act);
    else pass_count++;
    run_measure(64, 4095, 1'b1, c, p);   // start poked mid-window and in DONE
    run_measure(1, 4095, 1'b0, c, p);    // shortest window
  endtask

  task automatic test_reset_mid;
    int c, act; bit p;
    set_div(4, 1'b0, $urandom_range(0, 3));
    @(negedge clk);
    start   = 1'b1;
    win_len = 16'd64;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(19);
    #1 rst = 1'b0;
    #1;
    check_count++;
    if ({busy1, done1, cnt1, pass1, ovf1} !== '0)
      $display("FAIL reset_mid_outputs: got %0h expected 0", {busy1, done1, cnt1, pass1, ovf1});
    else pass_count++;
    act = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b1;
      if (done1 || busy1) act++;
    end
    check_count++;
    if (act !== 0)
      $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", act);
    else pass_count++;
    run_measure(64, 4095, 1'b0, c, p);
    check_count++;
    if (obs_cnt < 15 || obs_cnt > 17 || obs_pass !== 1'b1)
      $display("FAIL reset_mid_rerun: got cnt %0d pass %0b expected 15..17 pass 1", obs_cnt, obs_pass);
    else pass_count++;
  endtask

  task automatic test_random;
    int c, per, wl; bit p;
    for (int r = 0; r < 8; r++) begin
      per = 2 << $urandom_range(0, 2);
      wl  = $urandom_range(1, 200);
      set_div(per, 1'b0, $urandom_range(0, per - 1));
      idle_cycles($urandom_range(0, 5));
      run_measure(wl, 4095, 1'b0, c, p);
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_wrong_ratio;
    test_stopped;
    test_overflow;
    test_control;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_count, check_count);
    $fatal(1);
  end

endmodule
